// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave shifter and the register controller.
// The SPI slave (master modport) delivers received bytes; the controller
// (slave modport) returns the byte to shift out in the next slot.
interface spi_reg_ctrl_if;
    logic       cs_sync;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;

    modport master (
        output cs_sync,
        output rx_valid,
        output rx_data,
        input  tx_data
    );

    modport slave (
        input  cs_sync,
        input  rx_valid,
        input  rx_data,
        output tx_data
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Command sequencer and register bank behind the SPI slave byte link.
// Each chip-select frame carries one command byte (R/W, INC, address)
// followed by burst data bytes written to or read from the register bank.
module spi_reg_ctrl #(
    parameter int unsigned REGS = 16
) (
    input  logic                clk,
    input  logic                ar,
    spi_reg_ctrl_if.slave       bus,
    output logic [8*REGS-1:0]   regs_flat,
    output logic                wr_pulse,
    output logic [5:0]          wr_addr,
    output logic                busy
);

    localparam int unsigned AW      = $clog2(REGS);
    localparam logic [6:0]  RegsLim = 7'(REGS);

    typedef enum logic [1:0] {StIdle, StCmd, StWrite, StRead} state_e;

    state_e                     state_q, state_d;
    logic [5:0]                 addr_q, addr_d;
    logic                       inc_q, inc_d;
    logic                       err_q, err_d;
    logic [3:0]                 fcnt_q, fcnt_d;
    logic [REGS-1:0][7:0]       regs_q, regs_d;
    logic [7:0]                 tx_q, tx_d;
    logic                       wr_pulse_q, wr_pulse_d;
    logic [5:0]                 wr_addr_q, wr_addr_d;
    logic                       rd_load;

    function automatic logic in_range(input logic [5:0] a);
        return {1'b0, a} < RegsLim;
    endfunction

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (ar) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            inc_q      <= 1'b0;
            err_q      <= 1'b0;
            fcnt_q     <= '0;
            regs_q     <= '0;
            tx_q       <= '0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inc_q      <= inc_d;
            err_q      <= err_d;
            fcnt_q     <= fcnt_d;
            regs_q     <= regs_d;
            tx_q       <= tx_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    // Next-state, register-bank update and next tx byte.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inc_d      = inc_q;
        err_d      = err_q;
        fcnt_d     = fcnt_q;
        regs_d     = regs_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        rd_load    = 1'b0;
        tx_d       = 8'h00;

        if (bus.cs_sync) begin
            // Frame end wins over a coincident rx_valid; frame context is dropped.
            state_d = StIdle;
            addr_d  = '0;
            inc_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StCmd;
                StCmd: begin
                    if (bus.rx_valid) begin
                        addr_d = bus.rx_data[5:0];
                        inc_d  = bus.rx_data[6];
                        fcnt_d = fcnt_q + 4'd1;
                        if (bus.rx_data[7]) begin
                            state_d = StRead;
                            rd_load = 1'b1;
                        end else begin
                            state_d = StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (bus.rx_valid) begin
                        if (in_range(addr_q)) begin
                            regs_d[addr_q[AW-1:0]] = bus.rx_data;
                            wr_pulse_d             = 1'b1;
                            wr_addr_d              = addr_q;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (inc_q) addr_d = addr_q + 6'd1;
                    end
                end
                StRead: begin
                    if (bus.rx_valid) begin
                        rd_load = 1'b1;
                        if (inc_q) addr_d = addr_q + 6'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A read slot is fetched whenever the tx byte is (re)loaded in READ.
        if (rd_load && !in_range(addr_d)) err_d = 1'b1;

        unique case (state_d)
            StIdle, StCmd: tx_d = {err_d, 3'b000, fcnt_d};
            StRead:        tx_d = in_range(addr_d) ? regs_q[addr_d[AW-1:0]] : 8'h00;
            default:       tx_d = 8'h00;
        endcase
    end

    assign bus.tx_data = tx_q;
    assign regs_flat   = regs_q;
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: reset, burst write/read, wrap,
// out-of-range handling and aborted frames with hand-computed results.
module tb_spi_reg_ctrl;

    logic         clk = 1'b0;
    logic         ar;
    logic [127:0] regs_flat;
    logic         wr_pulse;
    logic [5:0]   wr_addr;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    logic [5:0] paddr [64];

    logic [7:0] t;
    logic       p;
    logic [5:0] wa;
    int         p0;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl #(.REGS(16)) dut (
        .clk       (clk),
        .ar        (ar),
        .bus       (bus),
        .regs_flat (regs_flat),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Log every write pulse and its address.
    always @(posedge clk) begin
        if (wr_pulse === 1'b1) begin
            paddr[pulse_cnt[5:0]] = wr_addr;
            pulse_cnt = pulse_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One byte slot; returns outputs one cycle after rx_valid.
    task automatic send(input logic [7:0] b, output logic [7:0] tx, output logic pl,
                        output logic [5:0] a);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick;
        tx = bus.tx_data;
        pl = wr_pulse;
        a  = wr_addr;
        bus.rx_valid = 1'b0;
        repeat (3) tick;
    endtask

    task automatic frame_end;
        bus.cs_sync = 1'b1;
        repeat (2) tick;
    endtask

    function automatic logic [7:0] regval(input int k);
        return regs_flat[8*k +: 8];
    endfunction

    initial begin
        ar           = 1'b1;
        bus.cs_sync  = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) tick;
        check("rst_busy", busy, 0);
        check("rst_tx", bus.tx_data, 8'h00);
        check("rst_regs", regs_flat, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_wr_addr", wr_addr, 0);
        ar = 1'b0;
        tick;
        check("post_rst_status", bus.tx_data, 8'h00);

        // Reset in the middle of a write burst.
        bus.cs_sync = 1'b0;
        check("busy_before_edge", busy, 0);
        tick;
        check("busy_rise", busy, 1);
        send(8'h40, t, p, wa);
        send(8'h12, t, p, wa);
        send(8'h34, t, p, wa);
        check("pre_rst_regs", regs_flat[15:0], 16'h3412);
        ar = 1'b1;
        tick;
        ar = 1'b0;
        bus.cs_sync = 1'b1;
        check("midrst_regs", regs_flat, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tx", bus.tx_data, 8'h00);
        tick;
        bus.cs_sync = 1'b0;
        repeat (2) tick;
        check("midrst_next_status", bus.tx_data, 8'h00);
        bus.cs_sync = 1'b1;
        tick;
        check("busy_fall", busy, 0);
        tick;

        // Burst write 0x43, 0xC3, 0xA3.
        p0 = pulse_cnt;
        bus.cs_sync = 1'b0;
        tick;
        send(8'h43, t, p, wa);
        check("bw_cmd_no_pulse", p, 0);
        send(8'hC3, t, p, wa);
        check("bw_pulse0", p, 1);
        check("bw_addr0", wa, 6'd3);
        send(8'hA3, t, p, wa);
        check("bw_pulse1", p, 1);
        check("bw_addr1", wa, 6'd4);
        frame_end;
        check("bw_reg3", regval(3), 8'hC3);
        check("bw_reg4", regval(4), 8'hA3);
        check("bw_npulse", pulse_cnt - p0, 2);
        check("bw_log0", paddr[p0], 6'd3);
        check("bw_log1", paddr[p0+1], 6'd4);

        // Burst read with INC.
        p0 = pulse_cnt;
        bus.cs_sync = 1'b0;
        repeat (2) tick;
        check("br_status", bus.tx_data, 8'h01);
        send(8'hC3, t, p, wa);
        check("br_tx0", t, 8'hC3);
        send(8'h00, t, p, wa);
        check("br_tx1", t, 8'hA3);
        send(8'h00, t, p, wa);
        frame_end;
        check("br_npulse", pulse_cnt - p0, 0);

        // Non-increment read.
        bus.cs_sync = 1'b0;
        tick;
        send(8'h83, t, p, wa);
        check("ni_tx0", t, 8'hC3);
        send(8'h00, t, p, wa);
        check("ni_tx1", t, 8'hC3);
        send(8'h00, t, p, wa);
        frame_end;
        check("ni_reg3", regval(3), 8'hC3);

        // Out-of-range write past reg15.
        p0 = pulse_cnt;
        bus.cs_sync = 1'b0;
        repeat (2) tick;
        check("oor_status_pre", bus.tx_data, 8'h03);
        send(8'h4F, t, p, wa);
        send(8'h11, t, p, wa);
        check("oor_addr15", wa, 6'd15);
        send(8'h22, t, p, wa);
        check("oor_drop_pulse", p, 0);
        frame_end;
        check("oor_reg15", regval(15), 8'h11);
        check("oor_npulse", pulse_cnt - p0, 1);

        // Address wrap 63 -> 0.
        p0 = pulse_cnt;
        bus.cs_sync = 1'b0;
        repeat (2) tick;
        check("err_status", bus.tx_data, 8'h84);
        send(8'h7F, t, p, wa);
        send(8'h55, t, p, wa);
        check("wrap_drop63", p, 0);
        send(8'h66, t, p, wa);
        check("wrap_addr0", wa, 6'd0);
        frame_end;
        check("wrap_reg0", regval(0), 8'h66);
        check("wrap_npulse", pulse_cnt - p0, 1);

        // Read across the end of the bank.
        bus.cs_sync = 1'b0;
        tick;
        send(8'hCF, t, p, wa);
        check("rd15", t, 8'h11);
        send(8'h00, t, p, wa);
        check("rd16_zero", t, 8'h00);
        frame_end;

        // Frame aborted inside the command byte.
        bus.cs_sync = 1'b0;
        repeat (4) tick;
        frame_end;
        bus.cs_sync = 1'b0;
        repeat (2) tick;
        check("abort_cmd_status", bus.tx_data, 8'h86);
        frame_end;

        // cs_sync rise coincident with a data byte.
        p0 = pulse_cnt;
        bus.cs_sync = 1'b0;
        tick;
        send(8'h41, t, p, wa);
        send(8'h77, t, p, wa);
        check("coin_first_addr", wa, 6'd1);
        bus.rx_data  = 8'h88;
        bus.rx_valid = 1'b1;
        bus.cs_sync  = 1'b1;
        tick;
        bus.rx_valid = 1'b0;
        check("coin_busy", busy, 0);
        check("coin_no_pulse", wr_pulse, 0);
        repeat (2) tick;
        check("coin_reg1", regval(1), 8'h77);
        check("coin_reg2", regval(2), 8'h00);
        check("coin_npulse", pulse_cnt - p0, 1);

        // rx_valid while idle is ignored.
        p0 = pulse_cnt;
        bus.rx_data  = 8'h99;
        bus.rx_valid = 1'b1;
        tick;
        bus.rx_valid = 1'b0;
        repeat (2) tick;
        check("idle_rx_busy", busy, 0);
        check("idle_rx_npulse", pulse_cnt - p0, 0);
        check("idle_status", bus.tx_data, 8'h87);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command sequencer and register bank behind the SPI slave byte interface. It parses each chip-select frame as one command byte followed by data bytes, and performs burst writes into an internal register bank or burst reads out of it. It also supplies the byte the SPI slave shifts out on `miso` for the next byte slot. The flattened register bank drives configuration of downstream blocks.

## Interface
- `REGS`, 16: number of 8-bit registers. Power of two, 2..64.
- `clk`  in  1  system clock.
- `ar`  in  1  reset; synchronous, active-high.
- `cs_sync`  in  1  chip select, already synchronized to `clk`, active-low.
- `rx_valid`  in  1  one-cycle pulse: the SPI slave has completed a byte.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `tx_data`  out  8  byte the SPI slave loads for the next byte slot.
- `regs_flat`  out  8*REGS  register bank; reg k is bits [8k+7:8k].
- `wr_pulse`  out  1  one-cycle pulse per completed register write.
- `wr_addr`  out  6  address of the write flagged by `wr_pulse`.
- `busy`  out  1  high while a frame is active (state is not IDLE).

## Operation
- Command byte format:
  - bit7 R/W: 1 = read, 0 = write.
  - bit6 INC: 1 = auto-increment address after each data byte.
  - bits5:0 start address A.
- FSM states:
  - IDLE: `cs_sync`=1. Go to CMD when `cs_sync`=0.
  - CMD: waiting for the command byte. On `rx_valid`, latch A and INC, then go to WRITE or READ per bit7.
  - WRITE: each `rx_valid` writes `rx_data` to reg[addr] if addr<REGS, pulses `wr_pulse`/`wr_addr`, then advances addr if INC.
  - READ: each `rx_valid` (the byte master sends is ignored) advances addr if INC and reloads `tx_data`.
  - Any state: `cs_sync`=1 returns to IDLE. Address and INC are discarded.
- `tx_data` per state:
  - IDLE/CMD: STATUS = {ERR, 3'b000, FCNT[3:0]}.
    - ERR: sticky flag, set by any out-of-range access, cleared only by `ar`.
    - FCNT: count of frames that reached WRITE or READ, mod 16; increments on the CMD exit.
  - READ: reg[addr], or 0x00 if addr≥REGS.
  - WRITE: 0x00.
- Address arithmetic: 6-bit, wraps 63→0.
  - Writes to addr≥REGS are dropped: no `wr_pulse`, ERR set.
  - Reads of addr≥REGS return 0x00 and set ERR.
- Unknown-bit rule: none. All 8 command bits are decoded as above.
- A frame with zero data bytes is legal: it changes no registers but still counts in FCNT.
- A frame that ends in CMD is not counted.

## Timing
- Reset (`ar`=1 at a `clk` edge) takes effect on that edge regardless of state, including mid-frame:
  - state = IDLE, all regs = 0x00, `tx_data` = 0x00;
  - `wr_pulse` = 0, `wr_addr` = 0, `busy` = 0, ERR = 0, FCNT = 0.
- After reset, `tx_data` takes the STATUS value (0x00) from the next edge.
- IDLE→CMD: `busy` rises 1 cycle after `cs_sync` falls.
- Any state→IDLE: `busy` falls 1 cycle after `cs_sync` rises.
- Write latency: `rx_valid` in cycle n → register and `regs_flat` updated, `wr_pulse`=1 in cycle n+1.
- Read latency: `rx_valid` in cycle n → `tx_data` holds the new byte in cycle n+1, stable until the next `rx_valid` or frame end.
  - The SPI slave guarantees at least 4 `clk` cycles between `rx_valid` and the first sck edge of the next byte.
- `rx_valid` in the same cycle `cs_sync`=1: the byte is ignored and the FSM goes to IDLE.
- `rx_valid` while in IDLE: ignored.
- A partial byte at `cs_sync` rise never produces `rx_valid`. No state is left pending.

## Test plan
- Reset mid-WRITE burst: assert `ar` one cycle.
  - All regs read 0x00.
  - `busy`=0, `tx_data`=0x00.
  - Next frame STATUS=0x00.
- Burst write: frame 0x43, 0xC3, 0xA3.
  - reg3=0xC3, reg4=0xA3.
  - Two `wr_pulse` with `wr_addr` 3 then 4.
  - STATUS after frame = 0x01.
- Burst read with INC: after the previous case, frame 0xC3, 0x00, 0x00.
  - `tx_data` sequence: STATUS 0x01 → 0xC3 → 0xA3.
  - No `wr_pulse`.
- Non-increment read: frame 0x83, 0x00, 0x00 → `tx_data` 0xC3 twice; reg3 is unchanged.
- Out-of-range and wrap with REGS=16:
  - Frame 0x4F, 0x11, 0x22 → reg15=0x11.
  - Byte 0x22 goes to addr 16: dropped, no pulse.
  - Next STATUS bit7=1.
  - Frame 0x7F, 0x55, 0x66 → 0x66 goes to reg0 (63→0 wrap).
- Aborted frames:
  - `cs_sync` high after 4 bits of the command byte → FCNT unchanged, no writes.
  - `cs_sync` rise coincident with `rx_valid` of a data byte → that byte is not written.
